// File: rtl/oam_dma_if.sv
// oam_dma_if: CPU-side trigger/handshake and memory-bus signals of the OAM DMA.
// master = system side (CPU + memory), slave = the DMA engine.
interface oam_dma_if #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned ADDR_WIDTH = 16
);
  logic                  cpu_we;
  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic [WIDTH-1:0]      cpu_din;
  logic                  cpu_rdy;
  logic                  dma_active;
  logic [ADDR_WIDTH-1:0] bus_addr;
  logic                  bus_we;
  logic [WIDTH-1:0]      bus_dout;
  logic [WIDTH-1:0]      bus_din;
  logic                  dma_done;

  modport master (
    output cpu_we, cpu_addr, cpu_din, bus_din,
    input  cpu_rdy, dma_active, bus_addr, bus_we, bus_dout, dma_done
  );

  modport slave (
    input  cpu_we, cpu_addr, cpu_din, bus_din,
    output cpu_rdy, dma_active, bus_addr, bus_we, bus_dout, dma_done
  );
endinterface

// File: rtl/oam_dma.sv
// oam_dma: sprite-attribute DMA. A CPU write of a page number to TRIGGER_ADDR
// halts the CPU and copies 256 bytes from that page to OAM_ADDR as alternating
// read/write bus cycles.
// Optional feature macro: OAM_DMA_ALIGN_EN -- when defined, an extra idle ALIGN
// cycle follows HALT if the free-running parity bit is 1 in HALT.
//
// state | meaning
// IDLE  | bus belongs to CPU, waiting for a trigger write
// HALT  | CPU halted, first cycle of ownership
// ALIGN | idle bus cycle to land the first read on an even cycle
// READ  | read {page, idx}, capture data into latch
// WRITE | write latch to OAM_ADDR, advance idx
// DONE  | one-cycle completion pulse, bus returned
module oam_dma #(
  parameter int unsigned           WIDTH        = 8,
  parameter int unsigned           ADDR_WIDTH   = 16,
  parameter logic [ADDR_WIDTH-1:0] TRIGGER_ADDR = 16'h4014,
  parameter logic [ADDR_WIDTH-1:0] OAM_ADDR     = 16'h2004
) (
  input logic      clk,
  input logic      reset_n,
  oam_dma_if.slave dma
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HALT,
    S_ALIGN,
    S_READ,
    S_WRITE,
    S_DONE
  } state_t;

  state_t                state;
  logic [WIDTH-1:0]      page;
  logic [7:0]            idx;
  logic [WIDTH-1:0]      latch;
  logic                  cpu_rdy_q;
  logic                  dma_active_q;
  logic [ADDR_WIDTH-1:0] bus_addr_q;
  logic                  bus_we_q;
  logic                  dma_done_q;
  logic                  trigger;

  assign trigger = dma.cpu_we && (dma.cpu_addr == TRIGGER_ADDR);

`ifdef OAM_DMA_ALIGN_EN
  logic parity;

  // Free-running cycle parity; decides whether the transfer needs an ALIGN cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) parity <= 1'b0;
    else          parity <= ~parity;
  end
`endif

  // Transfer sequencer; every output is registered alongside the state it belongs to.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      page         <= '0;
      idx          <= '0;
      latch        <= '0;
      cpu_rdy_q    <= 1'b1;
      dma_active_q <= 1'b0;
      bus_addr_q   <= '0;
      bus_we_q     <= 1'b0;
      dma_done_q   <= 1'b0;
    end else begin
      dma_done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (trigger) begin
            page         <= WIDTH'(dma.cpu_din[7:0]);
            idx          <= 8'h00;
            cpu_rdy_q    <= 1'b0;
            dma_active_q <= 1'b1;
            state        <= S_HALT;
          end
        end
        S_HALT: begin
`ifdef OAM_DMA_ALIGN_EN
          if (parity) begin
            state <= S_ALIGN;
          end else
`endif
          begin
            bus_addr_q <= ADDR_WIDTH'({page, idx});
            state      <= S_READ;
          end
        end
        S_ALIGN: begin
          bus_addr_q <= ADDR_WIDTH'({page, idx});
          state      <= S_READ;
        end
        S_READ: begin
          // Memory read is combinational, so the data is valid in this same cycle.
          latch      <= dma.bus_din;
          bus_addr_q <= OAM_ADDR;
          bus_we_q   <= 1'b1;
          state      <= S_WRITE;
        end
        S_WRITE: begin
          bus_we_q <= 1'b0;
          if (idx == 8'hFF) begin
            bus_addr_q   <= '0;
            cpu_rdy_q    <= 1'b1;
            dma_active_q <= 1'b0;
            dma_done_q   <= 1'b1;
            state        <= S_DONE;
          end else begin
            idx        <= idx + 8'd1;
            bus_addr_q <= ADDR_WIDTH'({page, idx + 8'd1});
            state      <= S_READ;
          end
        end
        S_DONE: begin
          // A trigger seen on this edge is deliberately dropped.
          state <= S_IDLE;
        end
        default: begin
          cpu_rdy_q    <= 1'b1;
          dma_active_q <= 1'b0;
          bus_addr_q   <= '0;
          bus_we_q     <= 1'b0;
          state        <= S_IDLE;
        end
      endcase
    end
  end

  assign dma.cpu_rdy    = cpu_rdy_q;
  assign dma.dma_active = dma_active_q;
  assign dma.bus_addr   = bus_addr_q;
  assign dma.bus_we     = bus_we_q;
  // bus_we_q is high only in WRITE, so write data is zero in every other state.
  assign dma.bus_dout   = bus_we_q ? latch : '0;
  assign dma.dma_done   = dma_done_q;

endmodule

// File: tb/tb_oam_dma.sv
// tb_oam_dma: directed + randomized transfers checked against a transfer-level
// reference model (expected reads/writes/cycle counts derived from the page and
// the cycle parity at the trigger edge).
module tb_oam_dma;

`ifdef OAM_DMA_ALIGN_EN
  localparam bit ALIGN_ON = 1'b1;
`else
  localparam bit ALIGN_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  oam_dma_if #(.WIDTH(8), .ADDR_WIDTH(16)) bus_if ();

  oam_dma #(
    .WIDTH(8),
    .ADDR_WIDTH(16),
    .TRIGGER_ADDR(16'h4014),
    .OAM_ADDR(16'h2004)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .dma(bus_if)
  );

  logic [7:0] mem [0:65535];
  assign bus_if.bus_din = mem[bus_if.bus_addr];

  // Clock edges since reset release; its LSB is the cycle parity.
  int edge_cnt;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) edge_cnt <= 0;
    else          edge_cnt <= edge_cnt + 1;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_transfer(input logic [7:0] p, input bit odd, input int retrig_at, input int abort_at);
    logic [15:0] reads[$];
    logic [7:0]  writes[$];
    int low, idle, dones, cyc, first_rd, last_wr, done_cyc, n0, oam_bad, we_after;
    bit exp_align;
    reads.delete();
    writes.delete();
    low = 0; idle = 0; dones = 0; first_rd = -1; last_wr = -1; done_cyc = -1; oam_bad = 0;

    @(negedge clk);
    while (((edge_cnt + 1) % 2) != int'(odd)) @(negedge clk);
    bus_if.cpu_we   = 1'b1;
    bus_if.cpu_addr = 16'h4014;
    bus_if.cpu_din  = p;
    @(negedge clk);
    bus_if.cpu_we   = 1'b0;
    bus_if.cpu_addr = 16'h0000;
    bus_if.cpu_din  = 8'h00;
    n0 = edge_cnt;
    exp_align = ALIGN_ON && ((n0 % 2) == 1);

    cyc = 0;
    forever begin
      bus_if.cpu_we = 1'b0;
      if (!bus_if.cpu_rdy) low++;
      if (bus_if.dma_active && !bus_if.bus_we) begin
        if (bus_if.bus_addr == 16'h0000) idle++;
        else begin
          if (first_rd < 0) first_rd = cyc;
          reads.push_back(bus_if.bus_addr);
        end
      end
      if (bus_if.bus_we) begin
        if (bus_if.bus_addr != 16'h2004) oam_bad++;
        writes.push_back(bus_if.bus_dout);
        last_wr = cyc;
      end
      if (bus_if.dma_done) begin
        dones++;
        done_cyc = cyc;
        check("done_cpu_rdy", 32'(bus_if.cpu_rdy), 32'd1);
      end
      if (retrig_at >= 0 && reads.size() == retrig_at + 1 && !bus_if.bus_we && bus_if.dma_active) begin
        bus_if.cpu_we   = 1'b1;
        bus_if.cpu_addr = 16'h4014;
        bus_if.cpu_din  = 8'h05;
      end
      if (abort_at >= 0 && reads.size() == abort_at + 1 && !bus_if.bus_we) begin
        reset_n = 1'b0;
        #1;
        check("abort_cpu_rdy", 32'(bus_if.cpu_rdy), 32'd1);
        check("abort_dma_active", 32'(bus_if.dma_active), 32'd0);
        check("abort_bus_we", 32'(bus_if.bus_we), 32'd0);
        check("abort_writes_so_far", 32'(writes.size()), 32'(abort_at));
        we_after = 0;
        repeat (4) begin
          @(negedge clk);
          if (bus_if.bus_we || bus_if.dma_active) we_after++;
        end
        check("abort_no_more_writes", 32'(we_after), 32'd0);
        reset_n = 1'b1;
        return;
      end
      if (done_cyc >= 0 && cyc > done_cyc) break;
      if (cyc >= 600) break;
      @(negedge clk);
      cyc++;
    end
    bus_if.cpu_we = 1'b0;

    check("transfer_completed", 32'(done_cyc >= 0), 32'd1);
    check("idle_after_cpu_rdy", 32'(bus_if.cpu_rdy), 32'd1);
    check("idle_after_active", 32'(bus_if.dma_active), 32'd0);
    check("idle_after_done", 32'(bus_if.dma_done), 32'd0);
    check("halted_cycles", 32'(low), 32'(513 + int'(exp_align)));
    check("idle_bus_cycles", 32'(idle), 32'(1 + int'(exp_align)));
    check("first_read_cycle", 32'(first_rd), 32'(1 + int'(exp_align)));
    check("last_write_cycle", 32'(last_wr), 32'(first_rd + 511));
    check("done_cycle", 32'(done_cyc), 32'(first_rd + 512));
    check("done_pulses", 32'(dones), 32'd1);
    check("oam_addr_bad", 32'(oam_bad), 32'd0);
    check("read_count", 32'(reads.size()), 32'd256);
    check("write_count", 32'(writes.size()), 32'd256);
    if (reads.size() == 256 && writes.size() == 256) begin
      for (int k = 0; k < 256; k++) begin
        check($sformatf("read_addr[%0d]", k), 32'(reads[k]), 32'({p, 8'(k)}));
        check($sformatf("write_data[%0d]", k), 32'(writes[k]), 32'(mem[{p, 8'(k)}]));
      end
    end
  endtask

  initial begin
    logic [7:0] rp;
    bit ro;
    bus_if.cpu_we   = 1'b0;
    bus_if.cpu_addr = 16'h0000;
    bus_if.cpu_din  = 8'h00;
    for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
    for (int i = 0; i < 256; i++) mem[16'h0200 + i] = 8'(i) ^ 8'hA5;

    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_cpu_rdy", 32'(bus_if.cpu_rdy), 32'd1);
    check("reset_dma_active", 32'(bus_if.dma_active), 32'd0);
    check("reset_bus_addr", 32'(bus_if.bus_addr), 32'd0);
    check("reset_bus_we", 32'(bus_if.bus_we), 32'd0);
    check("reset_bus_dout", 32'(bus_if.bus_dout), 32'd0);
    check("reset_dma_done", 32'(bus_if.dma_done), 32'd0);
    reset_n = 1'b1;

    // Non-trigger writes must not start a transfer.
    @(negedge clk);
    bus_if.cpu_we   = 1'b1;
    bus_if.cpu_addr = 16'h4015;
    bus_if.cpu_din  = 8'h02;
    @(negedge clk);
    bus_if.cpu_we   = 1'b0;
    check("non_trigger_cpu_rdy", 32'(bus_if.cpu_rdy), 32'd1);
    check("non_trigger_active", 32'(bus_if.dma_active), 32'd0);

    do_transfer(8'h02, 1'b0, -1, -1);
    do_transfer(8'h02, 1'b1, -1, -1);
    do_transfer(8'h02, 1'b0, 16, -1);
    do_transfer(8'h02, 1'b1, 16, -1);
    do_transfer(8'h02, 1'b0, -1, 64);
    do_transfer(8'h02, 1'b1, -1, -1);
    do_transfer(8'hFF, 1'b0, -1, -1);
    do_transfer(8'hFF, 1'b1, -1, -1);
    repeat (4) begin
      rp = 8'($urandom_range(1, 254));
      ro = 1'($urandom_range(0, 1));
      do_transfer(rp, ro, -1, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
